car_state_tx: RTL and testbench

- Serializes one board's own car state onto a single UART wire so the opponent board can drive the physics engine's other_f_x/other_f_y/other_r_x/other_r_y inputs.
- This block is the sending end of the inter-board car-state link.
- It sits beside the physics engine and samples that engine's collision centres, position, angle, lap flag and finish outputs.
- The top level issues one send_req per game tick while racing.

---
 rtl/car_link_pkg.sv | 29 ++
 rtl/uart_byte_tx.sv | 48 ++++
 rtl/car_state_tx.sv | 88 ++++++++
 tb/tb_car_state_tx.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/car_link_pkg.sv
// car_link_pkg: framing constants, payload layout and UART FSM encoding shared by the car-state link ends
package car_link_pkg;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int FRAME_BYTES = 11;
  localparam int PAYLOAD_BYTES = 9;
  localparam int PAYLOAD_W = 72;
  localparam int COORD_W = 10;
  localparam int ANG_W = 4;
  localparam int FLAG_W = 2;
  localparam int SEQ_W = 4;
  localparam int F_FX = 0;
  localparam int F_FY = 10;
  localparam int F_RX = 20;
  localparam int F_RY = 30;
  localparam int F_PX = 40;
  localparam int F_PY = 50;
  localparam int F_ANG = 60;
  localparam int F_FLAG = 64;
  localparam int F_FIN = 66;
  localparam int F_RSV = 67;
  localparam int F_SEQ = 68;
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;
  function automatic logic [7:0] payload_chk(input logic [PAYLOAD_W-1:0] p);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < PAYLOAD_BYTES; i++) c ^= p[8*i +: 8];
    return c;
  endfunction
endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: sends one 8N1 byte per load; a load in the last stop cycle chains the next byte gap-free
module uart_byte_tx
  import car_link_pkg::*;
#(
  parameter int BIT_CYC = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       done
);
  localparam int TW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [TW-1:0] LAST = TW'(BIT_CYC - 1);
  uart_state_t state, state_nx;
  logic [TW-1:0] tmr;
  logic [2:0] bit_idx;
  logic [7:0] sh;
  logic bit_end;
  assign bit_end = (state != ST_IDLE) && (tmr == LAST);
  assign done = (state == ST_STOP) && bit_end;
  assign tx = (state == ST_START) ? 1'b0 : (state == ST_DATA) ? sh[0] : 1'b1;
  // bit timer, shift register and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      tmr <= '0;
      bit_idx <= '0;
      sh <= '0;
    end else begin
      state <= state_nx;
      tmr <= (load || bit_end || state == ST_IDLE) ? '0 : tmr + 1'b1;
      if (load) sh <= byte_in;
      else if (state == ST_DATA && bit_end) sh <= sh >> 1;
      if (load) bit_idx <= '0;
      else if (state == ST_DATA && bit_end) bit_idx <= bit_idx + 3'd1;
    end
  end
  // next state: load always restarts at the start bit, otherwise advance at each bit end
  always_comb begin
    state_nx = state;
    if (load) state_nx = ST_START;
    else if (bit_end)
      state_nx = (state == ST_START) ? ST_DATA :
                 (state == ST_DATA) ? ((bit_idx == 3'd7) ? ST_STOP : ST_DATA) : ST_IDLE;
  end
endmodule

// File: rtl/car_state_tx.sv
// car_state_tx: snapshots own car state and sends it as an 11-byte UART frame to the opponent board
module car_state_tx
  import car_link_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD = 115200,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         send_req,
  input  logic [9:0]   my_f_x,
  input  logic [9:0]   my_f_y,
  input  logic [9:0]   my_r_x,
  input  logic [9:0]   my_r_y,
  input  logic [9:0]   pos_x,
  input  logic [9:0]   pos_y,
  input  logic [3:0]   angle_idx,
  input  logic [1:0]   flag,
  input  logic         finish,
  output logic         tx,
  output logic         busy,
  output logic         frame_done,
  output logic         overrun
);
  localparam int BIT_CYC = CLK_FREQ / BAUD;
  logic [PAYLOAD_W-1:0] payload, snap;
  logic [7:0] chk, byte_in;
  logic [SEQ_W-1:0] seq;
  logic [3:0] byte_idx, next_idx, pidx;
  logic accept, load, byte_done, last_byte;
  assign accept = send_req && !busy;
  assign last_byte = byte_idx == 4'(FRAME_BYTES - 1);
  assign load = accept || (byte_done && !last_byte);
  assign next_idx = byte_idx + 4'd1;
  assign pidx = next_idx - 4'd1;
  assign byte_in = accept ? SYNC_BYTE :
                   (next_idx == 4'(FRAME_BYTES - 1)) ? chk : 8'(payload >> {pidx, 3'b000});
  // pack the live inputs verbatim into the payload layout
  always_comb begin
    snap = '0;
    snap[F_FX +: COORD_W] = my_f_x;
    snap[F_FY +: COORD_W] = my_f_y;
    snap[F_RX +: COORD_W] = my_r_x;
    snap[F_RY +: COORD_W] = my_r_y;
    snap[F_PX +: COORD_W] = pos_x;
    snap[F_PY +: COORD_W] = pos_y;
    snap[F_ANG +: ANG_W] = angle_idx;
    snap[F_FLAG +: FLAG_W] = flag;
    snap[F_FIN] = finish;
    snap[F_RSV] = 1'b0;
    snap[F_SEQ +: SEQ_W] = seq;
  end
  // frame sequencing: snapshot on accept, step byte_idx per byte, close frame after the checksum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      payload <= '0;
      chk <= '0;
      seq <= '0;
      byte_idx <= '0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      frame_done <= byte_done && last_byte;
      overrun <= send_req && busy;
      if (accept) begin
        payload <= snap;
        chk <= payload_chk(snap);
        byte_idx <= '0;
        busy <= 1'b1;
      end else if (byte_done) begin
        if (last_byte) begin
          busy <= 1'b0;
          seq <= seq + 1'b1;
        end else byte_idx <= next_idx;
      end
    end
  end
  uart_byte_tx #(.BIT_CYC(BIT_CYC)) u_byte (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .byte_in(byte_in),
    .tx(tx),
    .done(byte_done)
  );
endmodule

// File: tb/tb_car_state_tx.sv
// tb_car_state_tx: scoreboard bench decoding the UART line against frames built from the driven inputs
module tb_car_state_tx;
  logic clk = 1'b0, rst_n = 1'b0, send_req = 1'b0;
  logic [9:0] my_f_x = '0, my_f_y = '0, my_r_x = '0, my_r_y = '0, pos_x = '0, pos_y = '0;
  logic [3:0] angle_idx = '0;
  logic [1:0] flag = '0;
  logic finish = 1'b0;
  logic tx, busy, frame_done, overrun;
  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  bit mon_en = 1'b1;

  car_state_tx #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk(clk), .rst_n(rst_n), .send_req(send_req),
    .my_f_x(my_f_x), .my_f_y(my_f_y), .my_r_x(my_r_x), .my_r_y(my_r_y),
    .pos_x(pos_x), .pos_y(pos_y), .angle_idx(angle_idx), .flag(flag), .finish(finish),
    .tx(tx), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic void push_frame(input logic [3:0] sq);
    logic [71:0] p;
    logic [7:0] c, b;
    p = {sq, 1'b0, finish, flag, angle_idx, pos_y, pos_x, my_r_y, my_r_x, my_f_y, my_f_x};
    exp_q.push_back(8'hA5);
    c = '0;
    for (int i = 0; i < 9; i++) begin
      b = p[8*i +: 8];
      exp_q.push_back(b);
      c ^= b;
    end
    exp_q.push_back(c);
  endfunction

  task automatic set_in(input logic [9:0] fx, input logic [9:0] px, input logic [3:0] ang,
                        input logic [1:0] flg, input logic fin);
    my_f_x = fx; my_f_y = '0; my_r_x = '0; my_r_y = '0; pos_x = px; pos_y = '0;
    angle_idx = ang; flag = flg; finish = fin;
  endtask

  task automatic pulse_req;
    @(negedge clk) send_req = 1'b1;
    @(negedge clk) send_req = 1'b0;
  endtask

  task automatic wait_idle(output int len);
    len = 0;
    while (busy === 1'b1 && len < 5000) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic apply_reset;
    @(negedge clk) rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    logic [7:0] b, e;
    logic sb, stp;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        repeat (7) @(negedge clk);
        sb = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk);
          b[i] = tx;
        end
        repeat (16) @(negedge clk);
        stp = tx;
        if (mon_en) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL byte_unexpected: got %02h, required no byte", b);
          end else begin
            e = exp_q.pop_front();
            if ({sb, b, stp} !== {1'b0, e, 1'b1}) begin
              errors++;
              $display("FAIL byte: got start=%b data=%02h stop=%b, required start=0 data=%02h stop=1",
                       sb, b, stp, e);
            end
          end
        end
      end
    end
  end

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({tx, busy, frame_done, overrun} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_outputs: got tx/busy/done/ovr=%b, required 1000", {tx, busy, frame_done, overrun});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_frame;
    logic [7:0] f [11] = '{8'hA5, 8'h64, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h64};
    int len;
    set_in(10'd100, '0, '0, '0, 1'b0);
    foreach (f[i]) exp_q.push_back(f[i]);
    pulse_req();
    checks++;
    if (busy !== 1'b1 || tx !== 1'b0) begin
      errors++;
      $display("FAIL single_start: got busy=%b tx=%b, required busy=1 tx=0", busy, tx);
    end
    wait_idle(len);
    checks++;
    if (len != 1760) begin
      errors++;
      $display("FAIL single_busy_len: got %0d, required 1760", len);
    end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL single_done: got %b, required 1", frame_done);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL single_done_pulse: got %b, required 0", frame_done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_bytes_left: got %0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_fields;
    logic [7:0] f [11] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h50, 8'h17, 8'h47};
    int len;
    set_in('0, '0, 4'd5, 2'd3, 1'b1);
    foreach (f[i]) exp_q.push_back(f[i]);
    pulse_req();
    wait_idle(len);
    checks++;
    if (len != 1760 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL fields_frame: got len=%0d left=%0d, required 1760 and 0", len, exp_q.size());
    end
  endtask

  task automatic test_snapshot;
    int len;
    set_in(10'd100, 10'd321, 4'd9, 2'd1, 1'b0);
    push_frame(4'd2);
    pulse_req();
    my_f_x = 10'd200;
    wait_idle(len);
    checks++;
    if (len != 1760 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL snapshot_first: got len=%0d left=%0d, required 1760 and 0", len, exp_q.size());
    end
    push_frame(4'd3);
    pulse_req();
    wait_idle(len);
    checks++;
    if (len != 1760 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL snapshot_second: got len=%0d left=%0d, required 1760 and 0", len, exp_q.size());
    end
  endtask

  task automatic test_overrun;
    int len;
    set_in(10'd777, 10'd45, 4'd14, 2'd2, 1'b1);
    my_r_x = 10'd512;
    push_frame(4'd4);
    pulse_req();
    repeat (498) @(negedge clk);
    send_req = 1'b1;
    @(negedge clk) send_req = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_pulse: got %b, required 1", overrun);
    end
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_width: got %b, required 0", overrun);
    end
    wait_idle(len);
    checks++;
    if (len != 1260) begin
      errors++;
      $display("FAIL overrun_busy_len: got %0d, required 1260", len);
    end
    repeat (50) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL overrun_extra_frame: got busy=%b left=%0d, required 0 and 0", busy, exp_q.size());
    end
  endtask

  task automatic test_back_to_back;
    int len;
    apply_reset();
    for (int k = 0; k < 17; k++) begin
      set_in(10'(k * 11), 10'(k * 37), 4'(k), 2'(k), k[0]);
      my_r_y = 10'(1000 - k);
      push_frame(4'(k % 16));
      send_req = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || tx !== 1'b0) begin
        errors++;
        $display("FAIL b2b_gap frame %0d: got busy=%b tx=%b, required 1 and 0", k, busy, tx);
      end
      if (k == 16) send_req = 1'b0;
      wait_idle(len);
      checks++;
      if (len != 1760 || frame_done !== 1'b1) begin
        errors++;
        $display("FAIL b2b_frame %0d: got len=%0d done=%b, required 1760 and 1", k, len, frame_done);
      end
      if (k < 16) begin
        checks++;
        if (overrun !== 1'b1) begin
          errors++;
          $display("FAIL b2b_overrun frame %0d: got %b, required 1", k, overrun);
        end
      end
    end
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_end: got busy=%b left=%0d, required 0 and 0", busy, exp_q.size());
    end
  endtask

  task automatic test_async_reset;
    int len;
    set_in(10'd5, 10'd6, 4'd7, 2'd1, 1'b0);
    push_frame(4'd1);
    pulse_req();
    repeat (299) @(negedge clk);
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got tx=%b busy=%b, required 1 and 0", tx, busy);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    exp_q.delete();
    mon_en = 1'b1;
    set_in(10'd900, 10'd3, 4'd2, 2'd0, 1'b1);
    push_frame(4'd0);
    pulse_req();
    wait_idle(len);
    checks++;
    if (len != 1760 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL after_reset_frame: got len=%0d left=%0d, required 1760 and 0", len, exp_q.size());
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_frame();
    test_fields();
    test_snapshot();
    test_overrun();
    test_back_to_back();
    test_async_reset();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
